// File: rtl/alu_result_drain.sv
// alu_result_drain: consumer end of the ALU result interface.
// Each accepted result is latched into the Z register pair and the flags are
// updated. The result is then drained onto the internal bus, lo word first,
// with a second hi beat for MUL and DIV. A one-deep pending buffer holds the
// next result while the current one is still draining.
// Ports:
//   i_clock, i_reset_n            clock, synchronous active-low reset
//   i_res_valid/o_res_ready       result handshake; i_res_op/lo/hi payload
//   o_bus_valid/i_bus_ready       bus handshake; o_bus_data word,
//   o_bus_sel_hi, o_bus_last      word select and final-beat marker
//   o_zlo_q, o_zhi_q              architectural Z registers
//   o_flag_zero, o_flag_neg       flags of the last loaded result
//   o_res_count                   fully drained results, wrapping
module alu_result_drain #(
    parameter int DATA_W  = 32,
    parameter int COUNT_W = 8
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_res_valid,
    output logic               o_res_ready,
    input  logic [4:0]         i_res_op,
    input  logic [DATA_W-1:0]  i_res_lo,
    input  logic [DATA_W-1:0]  i_res_hi,
    output logic               o_bus_valid,
    input  logic               i_bus_ready,
    output logic [DATA_W-1:0]  o_bus_data,
    output logic               o_bus_sel_hi,
    output logic               o_bus_last,
    output logic [DATA_W-1:0]  o_zlo_q,
    output logic [DATA_W-1:0]  o_zhi_q,
    output logic               o_flag_zero,
    output logic               o_flag_neg,
    output logic [COUNT_W-1:0] o_res_count
);
    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;

    typedef enum logic [1:0] {IDLE, SEND_LO, SEND_HI} state_t;

    state_t              r_state, w_next;
    logic                r_two;
    logic                r_pend_full;
    logic [4:0]          r_pend_op;
    logic [DATA_W-1:0]   r_pend_lo, r_pend_hi;
    logic [DATA_W-1:0]   r_zlo, r_zhi;
    logic                r_flag_zero, r_flag_neg;
    logic [COUNT_W-1:0]  r_count;

    logic                w_accept, w_bus_hs, w_complete, w_load, w_from_pend, w_pend_wr;
    logic [4:0]          w_src_op;
    logic [DATA_W-1:0]   w_src_lo, w_src_hi;
    logic                w_src_two, w_src_mul;

    assign o_res_ready  = !r_pend_full;
    assign w_accept     = i_res_valid && o_res_ready;
    assign o_bus_valid  = r_state != IDLE;
    assign w_bus_hs     = o_bus_valid && i_bus_ready;
    assign w_complete   = w_bus_hs && (r_state == SEND_HI || !r_two);
    // Completion hands Z to the pending result first, else straight to a
    // same-cycle accept so back-to-back results drain without a bubble.
    assign w_from_pend  = w_complete && r_pend_full;
    assign w_load       = (r_state == IDLE && w_accept) || (w_complete && (r_pend_full || w_accept));
    assign w_pend_wr    = w_accept && r_state != IDLE && !w_complete;

    assign w_src_op     = w_from_pend ? r_pend_op : i_res_op;
    assign w_src_lo     = w_from_pend ? r_pend_lo : i_res_lo;
    assign w_src_hi     = w_from_pend ? r_pend_hi : i_res_hi;
    assign w_src_mul    = w_src_op == OP_MUL;
    assign w_src_two    = w_src_mul || w_src_op == OP_DIV;

    assign o_bus_data   = r_state == SEND_HI ? r_zhi : r_zlo;
    assign o_bus_sel_hi = r_state == SEND_HI;
    assign o_bus_last   = r_state == SEND_HI || !r_two;
    assign o_zlo_q      = r_zlo;
    assign o_zhi_q      = r_zhi;
    assign o_flag_zero  = r_flag_zero;
    assign o_flag_neg   = r_flag_neg;
    assign o_res_count  = r_count;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_accept ? SEND_LO : IDLE;
            SEND_LO: if (w_bus_hs) w_next = r_two ? SEND_HI : (w_load ? SEND_LO : IDLE);
            SEND_HI: if (w_bus_hs) w_next = w_load ? SEND_LO : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state     <= IDLE;
            r_two       <= 1'b0;
            r_pend_full <= 1'b0;
            r_pend_op   <= '0;
            r_pend_lo   <= '0;
            r_pend_hi   <= '0;
            r_zlo       <= '0;
            r_zhi       <= '0;
            r_flag_zero <= 1'b0;
            r_flag_neg  <= 1'b0;
            r_count     <= '0;
        end else begin
            r_state <= w_next;
            if (w_complete) r_count <= r_count + 1'b1;
            if (w_from_pend) r_pend_full <= 1'b0;
            else if (w_pend_wr) r_pend_full <= 1'b1;
            if (w_pend_wr) begin
                r_pend_op <= i_res_op;
                r_pend_lo <= i_res_lo;
                r_pend_hi <= i_res_hi;
            end
            if (w_load) begin
                r_two       <= w_src_two;
                r_zlo       <= w_src_lo;
                r_zhi       <= w_src_two ? w_src_hi : '0;
                // DIV zero flag looks at the quotient only; MUL at the full product.
                r_flag_zero <= w_src_mul ? ({w_src_hi, w_src_lo} == '0) : (w_src_lo == '0);
                r_flag_neg  <= w_src_mul ? w_src_hi[DATA_W-1] : w_src_lo[DATA_W-1];
            end
        end
    end
endmodule

// File: tb/tb_alu_result_drain.sv
// tb_alu_result_drain: directed self-checking bench for alu_result_drain.
module tb_alu_result_drain;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        res_valid, res_ready, bus_valid, bus_ready, bus_sel_hi, bus_last;
    logic        flag_zero, flag_neg;
    logic [4:0]  res_op;
    logic [31:0] res_lo, res_hi, bus_data, zlo_q, zhi_q;
    logic [7:0]  res_count;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_cnt = 8'd0;

    always #5 clk = ~clk;

    alu_result_drain dut (
        .i_clock(clk), .i_reset_n(rst_n),
        .i_res_valid(res_valid), .o_res_ready(res_ready),
        .i_res_op(res_op), .i_res_lo(res_lo), .i_res_hi(res_hi),
        .o_bus_valid(bus_valid), .i_bus_ready(bus_ready),
        .o_bus_data(bus_data), .o_bus_sel_hi(bus_sel_hi), .o_bus_last(bus_last),
        .o_zlo_q(zlo_q), .o_zhi_q(zhi_q),
        .o_flag_zero(flag_zero), .o_flag_neg(flag_neg),
        .o_res_count(res_count)
    );

    typedef struct {
        logic [4:0]  op;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        two;
        logic        zero;
        logic        neg;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " bus_valid"}, {31'd0, bus_valid}, 32'd0);
        chk({tag, " zlo"}, zlo_q, 32'd0);
        chk({tag, " zhi"}, zhi_q, 32'd0);
        chk({tag, " flags"}, {30'd0, flag_zero, flag_neg}, 32'd0);
        chk({tag, " count"}, {24'd0, res_count}, 32'd0);
        chk({tag, " ready"}, {31'd0, res_ready}, 32'd1);
    endtask

    initial begin
        vecs[0]  = '{5'b00011, 32'h00000005, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{5'b01111, 32'hFFFFFFFE, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{5'b10000, 32'h00000000, 32'h00000007, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{5'b00100, 32'h80000000, 32'h00001234, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{5'b01111, 32'h00000000, 32'h00000000, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{5'b01111, 32'h00000000, 32'h80000000, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{5'b10000, 32'h80000001, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{5'b11111, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{5'b10010, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{5'b01111, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{5'b10000, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{5'b00111, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0};

        rst_n = 1'b0; res_valid = 1'b0; res_op = '0; res_lo = '0; res_hi = '0; bus_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset ready", {31'd0, res_ready}, 32'd1);
        chk("post-reset idle", {31'd0, bus_valid}, 32'd0);

        foreach (vecs[i]) begin
            res_valid = 1'b1; res_op = vecs[i].op; res_lo = vecs[i].lo; res_hi = vecs[i].hi;
            @(negedge clk);
            res_valid = 1'b0;
            chk($sformatf("v%0d valid lo", i), {31'd0, bus_valid}, 32'd1);
            chk($sformatf("v%0d data lo", i), bus_data, vecs[i].lo);
            chk($sformatf("v%0d sel/last lo", i), {30'd0, bus_sel_hi, bus_last}, {30'd0, 1'b0, !vecs[i].two});
            chk($sformatf("v%0d zlo", i), zlo_q, vecs[i].lo);
            chk($sformatf("v%0d zhi", i), zhi_q, vecs[i].two ? vecs[i].hi : 32'd0);
            chk($sformatf("v%0d flags", i), {30'd0, flag_zero, flag_neg}, {30'd0, vecs[i].zero, vecs[i].neg});
            if (vecs[i].two) begin
                @(negedge clk);
                chk($sformatf("v%0d data hi", i), bus_data, vecs[i].hi);
                chk($sformatf("v%0d sel/last hi", i), {30'd0, bus_sel_hi, bus_last}, 32'd3);
            end
            @(negedge clk);
            exp_cnt++;
            chk($sformatf("v%0d drained", i), {31'd0, bus_valid}, 32'd0);
            chk($sformatf("v%0d count", i), {24'd0, res_count}, {24'd0, exp_cnt});
        end

        // Backpressure: ADD(1) drains slowly, ADD(2) lands in pending, ADD(3) stalls.
        bus_ready = 1'b0; res_valid = 1'b1; res_op = 5'b00011; res_hi = '0; res_lo = 32'd1;
        @(negedge clk);
        chk("bp ready after 1", {31'd0, res_ready}, 32'd1);
        res_lo = 32'd2;
        @(negedge clk);
        res_lo = 32'd3;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bp hold data %0d", k), bus_data, 32'd1);
            chk($sformatf("bp hold ctl %0d", k), {29'd0, bus_valid, bus_sel_hi, bus_last}, 32'd5);
            chk($sformatf("bp ready low %0d", k), {31'd0, res_ready}, 32'd0);
            @(negedge clk);
        end
        bus_ready = 1'b1;
        @(negedge clk);
        chk("bp beat 2", bus_data, 32'd2);
        chk("bp ready back", {31'd0, res_ready}, 32'd1);
        @(negedge clk);
        res_valid = 1'b0;
        chk("bp beat 3", bus_data, 32'd3);
        chk("bp beat 3 valid", {31'd0, bus_valid}, 32'd1);
        @(negedge clk);
        exp_cnt += 8'd3;
        chk("bp count", {24'd0, res_count}, {24'd0, exp_cnt});
        chk("bp drained", {31'd0, bus_valid}, 32'd0);

        // Streaming: four ADDs back-to-back with bus_ready high.
        res_valid = 1'b1; res_lo = 32'd10;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("stream beat %0d", k), bus_data, 32'd10 + 32'(k));
            chk($sformatf("stream valid %0d", k), {31'd0, bus_valid}, 32'd1);
            chk($sformatf("stream ready %0d", k), {31'd0, res_ready}, 32'd1);
            res_lo = 32'd11 + 32'(k);
        end
        res_valid = 1'b0;
        @(negedge clk);
        exp_cnt += 8'd4;
        chk("stream count", {24'd0, res_count}, {24'd0, exp_cnt});

        // Reset while the lo beat of a MUL is on the bus: hi beat must never show.
        res_valid = 1'b1; res_op = 5'b01111; res_lo = 32'h12345678; res_hi = 32'h9ABCDEF0;
        @(negedge clk);
        res_valid = 1'b0;
        chk("mul lo before reset", bus_data, 32'h12345678);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_reset_state("mid-mul reset");
        @(negedge clk);
        chk("no hi beat", {31'd0, bus_valid}, 32'd0);
        chk("ready after reset", {31'd0, res_ready}, 32'd1);

        // Counter wrap: 256 single-word results drained.
        res_valid = 1'b1; res_op = 5'b01010; res_lo = 32'hA5A5A5A5;
        repeat (256) @(negedge clk);
        res_valid = 1'b0;
        chk("wrap count 255", {24'd0, res_count}, 32'd255);
        @(negedge clk);
        chk("wrap count 0", {24'd0, res_count}, 32'd0);
        chk("wrap drained", {31'd0, bus_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
